// File: rtl/cs_arb_pkg.sv
// Shared types and helpers for the chip-select round-robin arbiter.
// Provides the FSM state enum, the all-off select constant and rr_pick.
package cs_arb_pkg;

    localparam int CS_N_REQ_DEF = 8;
    localparam int CS_MAX_REQ   = 16;
    localparam int CS_PTR_W     = 4;

    localparam logic [CS_MAX_REQ-1:0] CS_ALL_OFF = '1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } cs_state_e;

    typedef struct packed {
        logic                found;
        logic [CS_PTR_W-1:0] idx;
    } rr_pick_t;

    // First set request searching ptr, ptr+1, ... wrapping at n.
    // ptr must be below n; indices never reach n.
    function automatic rr_pick_t rr_pick(
        input logic [CS_MAX_REQ-1:0] req,
        input logic [CS_PTR_W-1:0]   ptr,
        input int                    n
    );
        rr_pick_t            r;
        int                  j;
        logic [CS_PTR_W-1:0] jj;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < CS_MAX_REQ; i++) begin
            if (i < n) begin
                j = int'(ptr) + i;
                if (j >= n) begin
                    j = j - n;
                end
                jj = CS_PTR_W'(j);
                if (!r.found && req[jj]) begin
                    r.found = 1'b1;
                    r.idx   = jj;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_onehot_decode.sv
// Index to active-low one-hot select; all ones when off_n is high.
// Ports: idx (select index), off_n (1 = no select), sel_n (selects).
module cs_onehot_decode #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             off_n,
    output logic [N_REQ-1:0] sel_n
);

    // Compare per bit so an index >= N_REQ can never address a select.
    always_comb begin
        sel_n = '1;
        for (int i = 0; i < N_REQ; i++) begin
            if (!off_n && idx == IDX_W'(i)) begin
                sel_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cs_rr_arbiter.sv
// Round-robin chip-select arbiter with hold timeout and guard gap.
// Ports: clk, rst_n, en_n, req, done in; gnt_n, gnt_valid, gnt_idx, timeout_pls out.
module cs_rr_arbiter
    import cs_arb_pkg::*;
#(
    parameter int N_REQ     = CS_N_REQ_DEF,
    parameter int MAX_HOLD  = 16,
    parameter int GUARD_CYC = 1,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt_n,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout_pls
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam int GC_W = $clog2(GUARD_CYC + 1);

    cs_state_e        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GC_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic [N_REQ-1:0] gnt_n_q, gnt_n_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_pls_q, timeout_pls_d;

    rr_pick_t         pick;
    logic             pick_unused;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] ptr_inc;
    logic             own_rel;
    logic             hold_max;
    logic             start;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_off;

    assign pick        = rr_pick(CS_MAX_REQ'(req), CS_PTR_W'(ptr_q), N_REQ);
    assign pick_unused = ^pick.idx;
    assign win         = IDX_W'(pick.idx);
    assign start       = !en_n && pick.found;

    // Explicit wrap keeps non-power-of-two N_REQ in range.
    assign ptr_inc = (gnt_idx_q == IDX_W'(N_REQ - 1))
                   ? '0 : gnt_idx_q + IDX_W'(1);

    assign own_rel  = done[gnt_idx_q] || !req[gnt_idx_q];
    assign hold_max = (hold_cnt_q == HC_W'(MAX_HOLD));

    cs_onehot_decode #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx   (dec_idx),
        .off_n (dec_off),
        .sel_n (gnt_n_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_idx_q     <= '0;
            hold_cnt_q    <= '0;
            guard_cnt_q   <= '0;
            gnt_n_q       <= CS_ALL_OFF[N_REQ-1:0];
            gnt_valid_q   <= 1'b0;
            timeout_pls_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            hold_cnt_q    <= hold_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
            gnt_n_q       <= gnt_n_d;
            gnt_valid_q   <= gnt_valid_d;
            timeout_pls_q <= timeout_pls_d;
        end
    end

    // Next state, round-robin pointer and counters.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        guard_cnt_d = guard_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = GRANT;
                    hold_cnt_d = HC_W'(1);
                end
            end
            GRANT: begin
                if (en_n) begin
                    // Pointer kept so the interrupted requester goes first.
                    state_d     = GUARD;
                    hold_cnt_d  = '0;
                    guard_cnt_d = GC_W'(1);
                end else if (own_rel || hold_max) begin
                    state_d     = GUARD;
                    ptr_d       = ptr_inc;
                    hold_cnt_d  = '0;
                    guard_cnt_d = GC_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            GUARD: begin
                if (guard_cnt_q >= GC_W'(GUARD_CYC)) begin
                    state_d     = IDLE;
                    guard_cnt_d = '0;
                end else begin
                    guard_cnt_d = guard_cnt_q + GC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs; decoder result feeds gnt_n_q.
    always_comb begin
        dec_off       = 1'b1;
        dec_idx       = gnt_idx_q;
        gnt_idx_d     = gnt_idx_q;
        timeout_pls_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dec_off   = 1'b0;
                    dec_idx   = win;
                    gnt_idx_d = win;
                end
            end
            GRANT: begin
                if (!en_n && !own_rel) begin
                    if (hold_max) begin
                        timeout_pls_d = 1'b1;
                    end else begin
                        dec_off = 1'b0;
                    end
                end
            end
            default: begin
                dec_off = 1'b1;
            end
        endcase
        gnt_valid_d = !dec_off;
    end

    assign gnt_n       = gnt_n_q;
    assign gnt_valid   = gnt_valid_q;
    assign gnt_idx     = gnt_idx_q;
    assign timeout_pls = timeout_pls_q;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Directed scoreboard bench for cs_rr_arbiter (N_REQ=8, MAX_HOLD=4, GUARD_CYC=1).
// Expectations are queued when a cycle is driven and checked after its edge.
module tb_cs_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en_n;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt_n;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout_pls;

    typedef struct {
        string      tag;
        logic [7:0] gnt_n;
        logic [2:0] idx;
        logic       tp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cs_rr_arbiter #(
        .N_REQ     (8),
        .MAX_HOLD  (4),
        .GUARD_CYC (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_n        (en_n),
        .req         (req),
        .done        (done),
        .gnt_n       (gnt_n),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .timeout_pls (timeout_pls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] r,
                        input logic [7:0] d, input logic e,
                        input logic [7:0] eg, input logic [2:0] ei,
                        input logic et);
        exp_t x;
        req  = r;
        done = d;
        en_n = e;
        x.tag   = tag;
        x.gnt_n = eg;
        x.idx   = ei;
        x.tp    = et;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        cmp({x.tag, ".gnt_n"}, gnt_n, x.gnt_n);
        cmp({x.tag, ".valid"}, {7'd0, gnt_valid},
            {7'd0, x.gnt_n != 8'hFF});
        cmp({x.tag, ".idx"}, {5'd0, gnt_idx}, {5'd0, x.idx});
        cmp({x.tag, ".tp"}, {7'd0, timeout_pls}, {7'd0, x.tp});
        cmp({x.tag, ".onehot"}, {7'd0, $countones(~gnt_n) <= 1}, 8'd1);
    endtask

    initial begin
        int w;
        rst_n = 1'b1;
        en_n  = 1'b0;
        req   = 8'h00;
        done  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        cmp("rst.gnt_n", gnt_n, 8'hFF);
        cmp("rst.valid", {7'd0, gnt_valid}, 8'd0);
        cmp("rst.idx", {5'd0, gnt_idx}, 8'd0);
        cmp("rst.tp", {7'd0, timeout_pls}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, release by done, two-cycle gap, regrant.
        step("t1a", 8'h04, 8'h00, 1'b0, 8'hFB, 3'd2, 1'b0);
        step("t1b", 8'h04, 8'h00, 1'b0, 8'hFB, 3'd2, 1'b0);
        step("t1c", 8'h04, 8'h04, 1'b0, 8'hFF, 3'd2, 1'b0);
        step("t1d", 8'h04, 8'h00, 1'b0, 8'hFF, 3'd2, 1'b0);
        step("t1e", 8'h04, 8'h00, 1'b0, 8'hFB, 3'd2, 1'b0);

        // Asynchronous reset in the middle of a grant.
        #2 rst_n = 1'b0;
        #1;
        cmp("arst.gnt_n", gnt_n, 8'hFF);
        cmp("arst.valid", {7'd0, gnt_valid}, 8'd0);
        cmp("arst.idx", {5'd0, gnt_idx}, 8'd0);
        cmp("arst.tp", {7'd0, timeout_pls}, 8'd0);
        req = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All requesting; rotation from 0 after reset.
        for (int k = 0; k < 9; k++) begin
            w = k % 8;
            step($sformatf("rr%0d.g", k), 8'hFF, 8'h00, 1'b0,
                 ~(8'h01 << w), 3'(w), 1'b0);
            step($sformatf("rr%0d.r", k), 8'hFF, 8'h01 << w, 1'b0,
                 8'hFF, 3'(w), 1'b0);
            step($sformatf("rr%0d.q", k), 8'hFF, 8'h00, 1'b0,
                 8'hFF, 3'(w), 1'b0);
        end
        step("rr.idle", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0);

        // Hold timeout after exactly 4 cycles, then regrant.
        step("to1", 8'h20, 8'h00, 1'b0, 8'hDF, 3'd5, 1'b0);
        step("to2", 8'h20, 8'h00, 1'b0, 8'hDF, 3'd5, 1'b0);
        step("to3", 8'h20, 8'h00, 1'b0, 8'hDF, 3'd5, 1'b0);
        step("to4", 8'h20, 8'h00, 1'b0, 8'hDF, 3'd5, 1'b0);
        step("to5", 8'h20, 8'h00, 1'b0, 8'hFF, 3'd5, 1'b1);
        step("to6", 8'h20, 8'h00, 1'b0, 8'hFF, 3'd5, 1'b0);
        step("to7", 8'h20, 8'h00, 1'b0, 8'hDF, 3'd5, 1'b0);
        step("to8", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd5, 1'b0);
        step("to9", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd5, 1'b0);

        // Move pointer to 3 via a served grant on idx 2.
        step("p1", 8'h04, 8'h00, 1'b0, 8'hFB, 3'd2, 1'b0);
        step("p2", 8'h04, 8'h04, 1'b0, 8'hFF, 3'd2, 1'b0);
        step("p3", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd2, 1'b0);

        // Disable mid-grant; interrupted requester keeps priority.
        step("en1", 8'h08, 8'h00, 1'b0, 8'hF7, 3'd3, 1'b0);
        step("en2", 8'h08, 8'h00, 1'b1, 8'hFF, 3'd3, 1'b0);
        step("en3", 8'h88, 8'h00, 1'b1, 8'hFF, 3'd3, 1'b0);
        step("en4", 8'h88, 8'h00, 1'b1, 8'hFF, 3'd3, 1'b0);
        step("en5", 8'h88, 8'h00, 1'b1, 8'hFF, 3'd3, 1'b0);
        step("en6", 8'h88, 8'h00, 1'b0, 8'hF7, 3'd3, 1'b0);
        step("en7", 8'h88, 8'h08, 1'b0, 8'hFF, 3'd3, 1'b0);
        step("en8", 8'h88, 8'h00, 1'b0, 8'hFF, 3'd3, 1'b0);
        step("en9", 8'h88, 8'h00, 1'b0, 8'h7F, 3'd7, 1'b0);

        // Foreign done ignored; done at hold limit beats timeout.
        step("dh1", 8'h88, 8'h08, 1'b0, 8'h7F, 3'd7, 1'b0);
        step("dh2", 8'h88, 8'h00, 1'b0, 8'h7F, 3'd7, 1'b0);
        step("dh3", 8'h88, 8'h00, 1'b0, 8'h7F, 3'd7, 1'b0);
        step("dh4", 8'h88, 8'h80, 1'b0, 8'hFF, 3'd7, 1'b0);
        step("dh5", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd7, 1'b0);
        step("dh6", 8'h00, 8'h00, 1'b0, 8'hFF, 3'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
